hazard_controller: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core.
- Generates execute-stage forwarding selects for the forward_data_a / forward_data_b muxes, plus decode-stage branch-compare forwarding.
- Generates load-use and branch stalls (stall_f, stall_d, flush_e).
- Sequences the multi-cycle multiply/divide unit (MDU) with a busy counter, stalling HI/LO consumers until the result is written.

---
 rtl/CPU_def.sv | 21 ++
 rtl/mdu_sequencer.sv | 83 ++++++++
 rtl/hazard_controller.sv | 129 ++++++++++++
 tb/tb_hazard_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/CPU_def.sv
// rtl/CPU_def.sv - shared definitions for the 5-stage MIPS core hazard logic
//
// Purpose : register-specifier width, execute-stage forward-select encodings
//           and the MDU sequencer state type.
// Ports   : none (package).

package cpu_def;

  localparam int REG_BITS = 5;

  // Execute-stage operand mux selects.
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file read data
  localparam logic [1:0] FWD_WB  = 2'b01;  // result_w
  localparam logic [1:0] FWD_MEM = 2'b10;  // alu_out_m

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - busy counter/FSM for the multi-cycle multiply/divide unit
//
// Purpose : tracks how long the MDU is computing after a launch from E and
//           pulses mdu_done on the edge at which HI/LO are written.
// Ports   :
//   clk           in   core clock
//   reset         in   synchronous, active-high
//   mdu_start_e   in   mult/div launching from E this cycle
//   mdu_is_div_e  in   1 = divide latency, 0 = multiply latency
//   mdu_busy      out  high for exactly N cycles after the launch cycle
//   mdu_done      out  one-cycle pulse in the last busy cycle

module mdu_sequencer
  import cpu_def::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_BITS    = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic mdu_start_e,
  input  logic mdu_is_div_e,
  output logic mdu_busy,
  output logic mdu_done
);

  localparam logic [CNT_BITS-1:0] MULT_LOAD = CNT_BITS'(MULT_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] DIV_LOAD  = CNT_BITS'(DIV_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

  mdu_state_t          state_q, state_n;
  logic [CNT_BITS-1:0] count_q, count_n;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
    end
  end

  // Next-state logic. A start while BUSY is dropped: the decode stall keeps
  // a second mult/div out of E until the current one has finished.
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    case (state_q)
      MDU_IDLE: begin
        if (mdu_start_e) begin
          state_n = MDU_BUSY;
          count_n = mdu_is_div_e ? DIV_LOAD : MULT_LOAD;
        end
      end
      MDU_BUSY: begin
        if (count_q != '0) begin
          count_n = count_q - CNT_ONE;
        end else begin
          state_n = MDU_IDLE;
        end
      end
      default: begin
        state_n = MDU_IDLE;
        count_n = '0;
      end
    endcase
  end

  // Outputs are held low while reset is asserted, so an aborted sequence
  // never produces a done pulse.
  always_comb begin
    mdu_busy = 1'b0;
    mdu_done = 1'b0;
    if (!reset && state_q == MDU_BUSY) begin
      mdu_busy = 1'b1;
      mdu_done = (count_q == '0);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - forwarding, stall and MDU sequencing for the 5-stage MIPS core
//
// Purpose : execute-stage and branch-compare forwarding selects, load-use /
//           branch / HI-LO stalls, and the MDU busy sequencer.
// Ports   :
//   clk, reset                           core clock, sync active-high reset
//   rs_d, rt_d                           decode-stage source registers
//   branch_d, mdu_op_d, hilo_read_d      decode instruction class
//   rs_e, rt_e                           execute-stage source registers
//   write_reg_e/m/w, reg_write_e/m/w     destination and write enable per stage
//   mem_to_reg_e, mem_to_reg_m           stage holds a load
//   mdu_start_e, mdu_is_div_e            mult/div launch from E
//   forward_a_e, forward_b_e             E operand mux selects (00 RF, 01 W, 10 M)
//   forward_a_d, forward_b_d             forward alu_out_m into branch compare
//   stall_f, stall_d, flush_e            pipeline hold / bubble
//   mdu_busy, mdu_done                   MDU computing / HI-LO written

module hazard_controller
  import cpu_def::*;
#(
  parameter int REG_BITS    = cpu_def::REG_BITS,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_BITS    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_BITS-1:0] rs_d,
  input  logic [REG_BITS-1:0] rt_d,
  input  logic                branch_d,
  input  logic                mdu_op_d,
  input  logic                hilo_read_d,
  input  logic [REG_BITS-1:0] rs_e,
  input  logic [REG_BITS-1:0] rt_e,
  input  logic [REG_BITS-1:0] write_reg_e,
  input  logic [REG_BITS-1:0] write_reg_m,
  input  logic [REG_BITS-1:0] write_reg_w,
  input  logic                reg_write_e,
  input  logic                reg_write_m,
  input  logic                reg_write_w,
  input  logic                mem_to_reg_e,
  input  logic                mem_to_reg_m,
  input  logic                mdu_start_e,
  input  logic                mdu_is_div_e,
  output logic [1:0]          forward_a_e,
  output logic [1:0]          forward_b_e,
  output logic                forward_a_d,
  output logic                forward_b_d,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_e,
  output logic                mdu_busy,
  output logic                mdu_done
);

  // True when a stage will write a non-zero register equal to src.
  function automatic logic hits(input logic                en,
                                input logic [REG_BITS-1:0] dst,
                                input logic [REG_BITS-1:0] src);
    return en && (dst != '0) && (dst == src);
  endfunction

  // M is checked first: it holds the younger, more recent value.
  function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] src);
    if (hits(reg_write_m, write_reg_m, src)) return FWD_MEM;
    if (hits(reg_write_w, write_reg_w, src)) return FWD_WB;
    return FWD_RF;
  endfunction

  logic lw_stall;
  logic br_stall;
  logic mdu_stall;
  logic stall_any;
  logic mdu_active;

  mdu_sequencer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_BITS    (CNT_BITS)
  ) u_mdu_sequencer (
    .clk          (clk),
    .reset        (reset),
    .mdu_start_e  (mdu_start_e),
    .mdu_is_div_e (mdu_is_div_e),
    .mdu_busy     (mdu_active),
    .mdu_done     (mdu_done)
  );

  assign mdu_busy = mdu_active;

  always_comb begin
    // Load in E whose destination (rt_e) feeds the instruction in D.
    lw_stall = mem_to_reg_e && ((rt_e == rs_d) || (rt_e == rt_d));

    // Branch compares in D, so an ALU result still in E, or load data still
    // in M, cannot reach the comparator yet.
    br_stall = branch_d &&
               (hits(reg_write_e,  write_reg_e, rs_d) ||
                hits(reg_write_e,  write_reg_e, rt_d) ||
                hits(mem_to_reg_m, write_reg_m, rs_d) ||
                hits(mem_to_reg_m, write_reg_m, rt_d));

    // HI/LO consumers and further mult/divs wait while the MDU is running or
    // launching; this also covers the done cycle, releasing one cycle later.
    mdu_stall = (hilo_read_d || mdu_op_d) && (mdu_active || mdu_start_e);

    stall_any = lw_stall || br_stall || mdu_stall;
  end

  always_comb begin
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    forward_a_d = 1'b0;
    forward_b_d = 1'b0;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_e     = 1'b1;
    if (!reset) begin
      forward_a_e = fwd_sel(rs_e);
      forward_b_e = fwd_sel(rt_e);
      forward_a_d = hits(reg_write_m, write_reg_m, rs_d);
      forward_b_d = hits(reg_write_m, write_reg_m, rt_d);
      stall_f     = stall_any;
      stall_d     = stall_any;
      flush_e     = stall_any;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller

module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic       branch_d, mdu_op_d, hilo_read_d;
  logic [4:0] write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w;
  logic       mem_to_reg_e, mem_to_reg_m;
  logic       mdu_start_e, mdu_is_div_e;
  logic [1:0] forward_a_e, forward_b_e;
  logic       forward_a_d, forward_b_d;
  logic       stall_f, stall_d, flush_e;
  logic       mdu_busy, mdu_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk          (clk),
    .reset        (reset),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .branch_d     (branch_d),
    .mdu_op_d     (mdu_op_d),
    .hilo_read_d  (hilo_read_d),
    .rs_e         (rs_e),
    .rt_e         (rt_e),
    .write_reg_e  (write_reg_e),
    .write_reg_m  (write_reg_m),
    .write_reg_w  (write_reg_w),
    .reg_write_e  (reg_write_e),
    .reg_write_m  (reg_write_m),
    .reg_write_w  (reg_write_w),
    .mem_to_reg_e (mem_to_reg_e),
    .mem_to_reg_m (mem_to_reg_m),
    .mdu_start_e  (mdu_start_e),
    .mdu_is_div_e (mdu_is_div_e),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .forward_a_d  (forward_a_d),
    .forward_b_d  (forward_b_d),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_e      (flush_e),
    .mdu_busy     (mdu_busy),
    .mdu_done     (mdu_done)
  );

  // A second launch while the MDU is busy is illegal stimulus.
  always @(negedge clk) begin
    if (!reset && mdu_busy && mdu_start_e) begin
      errors++;
      $display("FAIL mdu_start_while_busy: start=%0b busy=%0b required no start while busy",
               mdu_start_e, mdu_busy);
    end
  end

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    branch_d = 0; mdu_op_d = 0; hilo_read_d = 0;
    write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_to_reg_e = 0; mem_to_reg_m = 0;
    mdu_start_e = 0; mdu_is_div_e = 0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rs_e = 8; rt_e = 8; write_reg_m = 8; reg_write_m = 1;
    write_reg_w = 8; reg_write_w = 1;
    mem_to_reg_e = 1; rs_d = 8; rt_d = 8;
    branch_d = 1; reg_write_e = 1; write_reg_e = 8;
    hilo_read_d = 1; mdu_start_e = 1;
    step();
    step();
    @(negedge clk);
    checks++;
    if (flush_e !== 1'b1) begin errors++; $display("FAIL reset_flush: got %0b want 1", flush_e); end
    checks++;
    if ({stall_f, stall_d} !== 2'b00) begin errors++; $display("FAIL reset_stall: got %b want 00", {stall_f, stall_d}); end
    checks++;
    if ({forward_a_e, forward_b_e} !== 4'b0000) begin errors++; $display("FAIL reset_fwd_e: got %b want 0000", {forward_a_e, forward_b_e}); end
    checks++;
    if ({mdu_busy, mdu_done} !== 2'b00) begin errors++; $display("FAIL reset_mdu: got %b want 00", {mdu_busy, mdu_done}); end
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if ({flush_e, stall_f, mdu_busy} !== 3'b000) begin errors++; $display("FAIL post_reset_idle: got %b want 000", {flush_e, stall_f, mdu_busy}); end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    rs_e = 8; rt_e = 8;
    write_reg_m = 8; reg_write_m = 1;
    write_reg_w = 8; reg_write_w = 1;
    #1;
    checks++;
    if (forward_a_e !== 2'b10) begin errors++; $display("FAIL fwd_a_m_prio: got %b want 10", forward_a_e); end
    checks++;
    if (forward_b_e !== 2'b10) begin errors++; $display("FAIL fwd_b_m_prio: got %b want 10", forward_b_e); end
    reg_write_m = 0;
    #1;
    checks++;
    if (forward_a_e !== 2'b01) begin errors++; $display("FAIL fwd_a_w: got %b want 01", forward_a_e); end
    rs_e = 0; rt_e = 7; write_reg_m = 0; write_reg_w = 0;
    reg_write_m = 1; reg_write_w = 1;
    #1;
    checks++;
    if (forward_a_e !== 2'b00) begin errors++; $display("FAIL fwd_a_r0: got %b want 00", forward_a_e); end
    write_reg_m = 8; write_reg_w = 7;
    #1;
    checks++;
    if (forward_b_e !== 2'b01) begin errors++; $display("FAIL fwd_b_w_only: got %b want 01", forward_b_e); end
    checks++;
    if (stall_f !== 1'b0) begin errors++; $display("FAIL fwd_no_stall: got %b want 0", stall_f); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    step();
    mem_to_reg_e = 1; rt_e = 5; rs_d = 5; rt_d = 9;
    @(negedge clk);
    checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b111) begin errors++; $display("FAIL lw_stall_rs: got %b want 111", {stall_f, stall_d, flush_e}); end
    step();
    rt_e = 6; rs_d = 5; rt_d = 7;
    @(negedge clk);
    checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b000) begin errors++; $display("FAIL lw_no_stall: got %b want 000", {stall_f, stall_d, flush_e}); end
    step();
    rt_e = 7;
    @(negedge clk);
    checks++;
    if (stall_d !== 1'b1) begin errors++; $display("FAIL lw_stall_rt: got %b want 1", stall_d); end
  endtask

  task automatic test_branch();
    clear_inputs();
    step();
    branch_d = 1; rs_d = 3; rt_d = 4;
    reg_write_e = 1; write_reg_e = 3;
    @(negedge clk);
    checks++;
    if ({stall_f, flush_e} !== 2'b11) begin errors++; $display("FAIL br_stall_e: got %b want 11", {stall_f, flush_e}); end
    checks++;
    if (forward_a_d !== 1'b0) begin errors++; $display("FAIL br_fwd_a_d_e: got %b want 0", forward_a_d); end
    step();
    reg_write_e = 0; write_reg_e = 0;
    reg_write_m = 1; write_reg_m = 3; mem_to_reg_m = 0;
    @(negedge clk);
    checks++;
    if (stall_f !== 1'b0) begin errors++; $display("FAIL br_stall_m_alu: got %b want 0", stall_f); end
    checks++;
    if ({forward_a_d, forward_b_d} !== 2'b10) begin errors++; $display("FAIL br_fwd_d: got %b want 10", {forward_a_d, forward_b_d}); end
    step();
    mem_to_reg_m = 1; write_reg_m = 4;
    @(negedge clk);
    checks++;
    if (stall_d !== 1'b1) begin errors++; $display("FAIL br_stall_m_load: got %b want 1", stall_d); end
    branch_d = 0;
    #1;
    checks++;
    if (stall_d !== 1'b0) begin errors++; $display("FAIL no_branch_no_stall: got %b want 0", stall_d); end
  endtask

  task automatic run_mult(input string tag, input logic read_hilo);
    clear_inputs();
    step();
    mdu_start_e = 1; mdu_is_div_e = 0; hilo_read_d = read_hilo;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (mdu_busy !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL %s_busy c%0d: got %b want %b", tag, c, mdu_busy, (c >= 1 && c <= 4)); end
      checks++;
      if (mdu_done !== (c == 4)) begin errors++; $display("FAIL %s_done c%0d: got %b want %b", tag, c, mdu_done, (c == 4)); end
      if (read_hilo) begin
        checks++;
        if (stall_f !== (c <= 4)) begin errors++; $display("FAIL %s_stall c%0d: got %b want %b", tag, c, stall_f, (c <= 4)); end
      end
      step();
      mdu_start_e = 0;
    end
    hilo_read_d = 0;
  endtask

  task automatic test_multiply();
    run_mult("mult", 1'b1);
  endtask

  task automatic test_divide_reset();
    int done_seen;
    done_seen = 0;
    clear_inputs();
    step();
    mdu_start_e = 1; mdu_is_div_e = 1;
    for (int c = 0; c <= 16; c++) begin
      if (c == 10) reset = 1'b1;
      if (c == 11) reset = 1'b0;
      @(negedge clk);
      if (mdu_done === 1'b1) done_seen++;
      if (c >= 1 && c <= 9) begin
        checks++;
        if (mdu_busy !== 1'b1) begin errors++; $display("FAIL div_busy c%0d: got %b want 1", c, mdu_busy); end
      end
      if (c >= 11) begin
        checks++;
        if (mdu_busy !== 1'b0) begin errors++; $display("FAIL div_abort c%0d: got %b want 0", c, mdu_busy); end
      end
      step();
      mdu_start_e = 0;
    end
    checks++;
    if (done_seen !== 0) begin errors++; $display("FAIL div_no_done: got %0d pulses want 0", done_seen); end
    run_mult("mult_after_div", 1'b0);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_multiply();
    test_divide_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
